control_sequencer: RTL and testbench

- Parametrised successor to the fixed-length 8-bit CPU control block.
- Generates the 15-bit control word consumed by the PC, MAR/RAM, IR, accumulator, ALU, B and output registers.
- Adds variable-length instructions, flag-conditional jumps (JC/JZ), a sticky HALT and configurable T-state depth.
- Sits between the instruction register (opcode) / ALU (flags) and every datapath block on the shared bus.

---
 rtl/cpu_ctrl_pkg.sv | 53 +++++
 rtl/tstate_counter.sv | 53 +++++
 rtl/control_sequencer.sv | 144 ++++++++++++++
 tb/tb_control_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control sequencer: opcodes, control-word bit
// indices, the idle word and the per-opcode last-step lookup.
package cpu_ctrl_pkg;

  localparam int unsigned CTRL_W = 15;
  typedef logic [CTRL_W-1:0] ctrl_t;

  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
    T4 = 3'd4, T5 = 3'd5, T6 = 3'd6, T7 = 3'd7
  } tstate_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int unsigned CB_CP   = 14;
  localparam int unsigned CB_EP   = 13;
  localparam int unsigned CB_LP   = 12;
  localparam int unsigned CB_NLMA = 11;
  localparam int unsigned CB_NLMD = 10;
  localparam int unsigned CB_NCE  = 9;
  localparam int unsigned CB_NLR  = 8;
  localparam int unsigned CB_NLI  = 7;
  localparam int unsigned CB_NEI  = 6;
  localparam int unsigned CB_NLA  = 5;
  localparam int unsigned CB_EA   = 4;
  localparam int unsigned CB_SUB  = 3;
  localparam int unsigned CB_EU   = 2;
  localparam int unsigned CB_NLB  = 1;
  localparam int unsigned CB_NLO  = 0;

  // Active-low strobes high, active-high strobes low.
  localparam ctrl_t CTRL_IDLE = 15'h0FE3;

  function automatic tstate_e last_step_f(input logic [3:0] op);
    case (op)
      OP_LDA:                                        return T3;
      OP_ADD, OP_SUB, OP_STA:                        return T4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: return T2;
      default:                                       return T1;
    endcase
  endfunction

endpackage

// File: rtl/tstate_counter.sv
// T-state register with early return to T0, wrap at MAX_T-1 and the sticky
// halt freeze.
module tstate_counter
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MAX_T        = 6,
  parameter int unsigned VARIABLE_LEN = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    advance,
  input  tstate_e last_step,
  input  logic    halt_now,
  output tstate_e tstate,
  output logic    halted
);

  localparam logic [2:0] T_WRAP = 3'(MAX_T - 1);

  tstate_e tstate_q, tstate_d;
  logic    halted_q, halted_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tstate_q <= T0;
      halted_q <= 1'b0;
    end else begin
      tstate_q <= tstate_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    tstate_d = tstate_q;
    halted_d = halted_q;
    if (advance && !halted_q) begin
      if (halt_now) begin
        halted_d = 1'b1;
        tstate_d = T0;
      end else if ((VARIABLE_LEN != 0) && (tstate_q == last_step)) begin
        tstate_d = T0;
      end else if (tstate_q == T_WRAP) begin
        tstate_d = T0;
      end else begin
        tstate_d = tstate_e'(tstate_q + 3'd1);
      end
    end
  end

  assign tstate = tstate_q;
  assign halted = halted_q;

endmodule

// File: rtl/control_sequencer.sv
// Control-word sequencer for the 8-bit CPU datapath.
// Optional single-step gating is enabled by defining CTRL_SINGLE_STEP_EN.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W     = 4,
  parameter int unsigned MAX_T        = 6,
  parameter int unsigned VARIABLE_LEN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                cf,
  input  logic                zf,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic                step,
`endif
  output logic [14:0]         out,
  output logic [2:0]          tstate,
  output logic                halted
);

  logic [3:0] op4;
  logic       advance;
  logic       halt_now;
  tstate_e    t_cur;
  ctrl_t      ctrl_word;

  generate
    if (OPCODE_W > 4) begin : g_wide_op
      assign op4 = (|opcode[OPCODE_W-1:4]) ? OP_NOP : opcode[3:0];
    end else begin : g_narrow_op
      assign op4 = opcode[3:0];
    end
  endgenerate

`ifdef CTRL_SINGLE_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  assign halt_now = (op4 == OP_HLT) && (t_cur == T2);

  tstate_counter #(
    .MAX_T       (MAX_T),
    .VARIABLE_LEN(VARIABLE_LEN)
  ) u_tstate_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (advance),
    .last_step(last_step_f(op4)),
    .halt_now (halt_now),
    .tstate   (t_cur),
    .halted   (halted)
  );

  assign tstate = t_cur;

  always_comb begin
    ctrl_word = CTRL_IDLE;
    case (t_cur)
      T0: begin
        ctrl_word[CB_EP]   = 1'b1;
        ctrl_word[CB_NLMA] = 1'b0;
      end
      T1: begin
        ctrl_word[CB_CP]  = 1'b1;
        ctrl_word[CB_NCE] = 1'b0;
        ctrl_word[CB_NLI] = 1'b0;
      end
      T2: begin
        case (op4)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl_word[CB_NEI]  = 1'b0;
            ctrl_word[CB_NLMA] = 1'b0;
          end
          OP_LDI: begin
            ctrl_word[CB_NEI] = 1'b0;
            ctrl_word[CB_NLA] = 1'b0;
          end
          OP_JMP: begin
            ctrl_word[CB_NEI] = 1'b0;
            ctrl_word[CB_LP]  = 1'b1;
          end
          OP_JC: begin
            if (cf) begin
              ctrl_word[CB_NEI] = 1'b0;
              ctrl_word[CB_LP]  = 1'b1;
            end
          end
          OP_JZ: begin
            if (zf) begin
              ctrl_word[CB_NEI] = 1'b0;
              ctrl_word[CB_LP]  = 1'b1;
            end
          end
          OP_OUT: begin
            ctrl_word[CB_EA]  = 1'b1;
            ctrl_word[CB_NLO] = 1'b0;
          end
          default: ;
        endcase
      end
      T3: begin
        case (op4)
          OP_LDA: begin
            ctrl_word[CB_NCE] = 1'b0;
            ctrl_word[CB_NLA] = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            ctrl_word[CB_NCE] = 1'b0;
            ctrl_word[CB_NLB] = 1'b0;
          end
          OP_STA: begin
            ctrl_word[CB_EA]   = 1'b1;
            ctrl_word[CB_NLMD] = 1'b0;
          end
          default: ;
        endcase
      end
      T4: begin
        case (op4)
          OP_ADD: begin
            ctrl_word[CB_EU]  = 1'b1;
            ctrl_word[CB_NLA] = 1'b0;
          end
          OP_SUB: begin
            ctrl_word[CB_EU]  = 1'b1;
            ctrl_word[CB_NLA] = 1'b0;
            ctrl_word[CB_SUB] = 1'b1;
          end
          OP_STA: ctrl_word[CB_NLR] = 1'b0;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Reset, halt and stall all force the idle word so no strobe fires or repeats.
  assign out = (rst_n && !halted && advance) ? ctrl_word : CTRL_IDLE;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: variable-length and fixed-length instances.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic        cf = 1'b0;
  logic        zf = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
  logic        step = 1'b1;
`endif
  logic [14:0] out_v, out_f;
  logic [2:0]  ts_v, ts_f;
  logic        h_v, h_f;

  always #5 clk = ~clk;

  control_sequencer #(.OPCODE_W(4), .MAX_T(6), .VARIABLE_LEN(1)) u_var (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .cf(cf), .zf(zf),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .out(out_v), .tstate(ts_v), .halted(h_v)
  );

  control_sequencer #(.OPCODE_W(4), .MAX_T(6), .VARIABLE_LEN(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .cf(cf), .zf(zf),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .out(out_f), .tstate(ts_f), .halted(h_f)
  );

  typedef struct {
    string       nm;
    int unsigned sel;
    logic [2:0]  t;
    logic [14:0] o;
    logic        h;
  } exp_s;

  exp_s        sbq[$];
  int unsigned total = 0;
  int unsigned bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      exp_s e;
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.sel == 0) begin
          chk($sformatf("%s.tstate", e.nm), 32'(ts_v), 32'(e.t));
          chk($sformatf("%s.out", e.nm), 32'(out_v), 32'(e.o));
          chk($sformatf("%s.halted", e.nm), 32'(h_v), 32'(e.h));
        end else begin
          chk($sformatf("%s.tstate", e.nm), 32'(ts_f), 32'(e.t));
          chk($sformatf("%s.out", e.nm), 32'(out_f), 32'(e.o));
          chk($sformatf("%s.halted", e.nm), 32'(h_f), 32'(e.h));
        end
      end
    end
  endtask

  task automatic push(input string nm, input int unsigned sel, input logic [2:0] t,
                      input logic [14:0] o, input logic h);
    exp_s e;
    e.nm = nm; e.sel = sel; e.t = t; e.o = o; e.h = h;
    sbq.push_back(e);
  endtask

  // Drive one cycle's inputs, queue its expected response, advance one clock.
  task automatic cyc(input string nm, input int unsigned sel, input logic [3:0] op,
                     input logic c, input logic z, input logic [2:0] t,
                     input logic [14:0] o, input logic h);
    opcode = op; cf = c; zf = z;
    push(nm, sel, t, o, h);
    @(posedge clk); #1;
  endtask

  task automatic ins_v(input string nm, input logic [3:0] op, input logic c, input logic z,
                       input int unsigned last, input logic [14:0] w2,
                       input logic [14:0] w3, input logic [14:0] w4);
    cyc({nm, "_t0"}, 0, op, c, z, 3'd0, 15'h27E3, 1'b0);
    cyc({nm, "_t1"}, 0, op, c, z, 3'd1, 15'h4D63, 1'b0);
    if (last >= 2) cyc({nm, "_t2"}, 0, op, c, z, 3'd2, w2, 1'b0);
    if (last >= 3) cyc({nm, "_t3"}, 0, op, c, z, 3'd3, w3, 1'b0);
    if (last >= 4) cyc({nm, "_t4"}, 0, op, c, z, 3'd4, w4, 1'b0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    rst_n = 1'b0;
    #2;
    chk("reset_tstate", 32'(ts_v), 32'd0);
    chk("reset_out", 32'(out_v), 32'h0FE3);
    chk("reset_halted", 32'(h_v), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    ins_v("ldi",  4'h5, 1'b0, 1'b0, 2, 15'h0F83, 15'h0,    15'h0);
    ins_v("add",  4'h2, 1'b0, 1'b0, 4, 15'h07A3, 15'h0DE1, 15'h0FC7);
    ins_v("sub",  4'h3, 1'b0, 1'b0, 4, 15'h07A3, 15'h0DE1, 15'h0FCF);
    ins_v("lda",  4'h1, 1'b0, 1'b0, 3, 15'h07A3, 15'h0DC3, 15'h0);
    ins_v("sta",  4'h4, 1'b0, 1'b0, 4, 15'h07A3, 15'h0BF3, 15'h0EE3);
    ins_v("jmp",  4'h6, 1'b0, 1'b0, 2, 15'h1FA3, 15'h0,    15'h0);
    ins_v("jc1",  4'h7, 1'b1, 1'b0, 2, 15'h1FA3, 15'h0,    15'h0);
    ins_v("jc0",  4'h7, 1'b0, 1'b1, 2, 15'h0FE3, 15'h0,    15'h0);
    ins_v("jz1",  4'h8, 1'b0, 1'b1, 2, 15'h1FA3, 15'h0,    15'h0);
    ins_v("jz0",  4'h8, 1'b1, 1'b0, 2, 15'h0FE3, 15'h0,    15'h0);
    ins_v("outi", 4'hE, 1'b0, 1'b0, 2, 15'h0FF2, 15'h0,    15'h0);
    ins_v("nop",  4'h0, 1'b0, 1'b0, 1, 15'h0,    15'h0,    15'h0);
    ins_v("undef",4'h9, 1'b0, 1'b0, 1, 15'h0,    15'h0,    15'h0);

    // JC with carry rising partway through T2 must switch Lp in the same cycle.
    cyc("jcflip_t0", 0, 4'h7, 1'b0, 1'b0, 3'd0, 15'h27E3, 1'b0);
    cyc("jcflip_t1", 0, 4'h7, 1'b0, 1'b0, 3'd1, 15'h4D63, 1'b0);
    opcode = 4'h7; cf = 1'b0;
    push("jcflip_t2", 0, 3'd2, 15'h0FE3, 1'b0);
    @(negedge clk); #1;
    cf = 1'b1;
    #1;
    chk("jcflip_live_out", 32'(out_v), 32'h1FA3);
    @(posedge clk); #1;
    cf = 1'b0;

    ins_v("hlt", 4'hF, 1'b0, 1'b0, 2, 15'h0FE3, 15'h0, 15'h0);
    for (int i = 0; i < 20; i++) cyc("halted", 0, 4'h5, 1'b0, 1'b0, 3'd0, 15'h0FE3, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("halt_clear", 32'(h_v), 32'd0);
    chk("halt_clear_out", 32'(out_v), 32'h0FE3);
    @(posedge clk); #1;
    rst_n = 1'b1;

    cyc("fix_ldi_t0", 1, 4'h5, 1'b0, 1'b0, 3'd0, 15'h27E3, 1'b0);
    cyc("fix_ldi_t1", 1, 4'h5, 1'b0, 1'b0, 3'd1, 15'h4D63, 1'b0);
    cyc("fix_ldi_t2", 1, 4'h5, 1'b0, 1'b0, 3'd2, 15'h0F83, 1'b0);
    cyc("fix_ldi_t3", 1, 4'h5, 1'b0, 1'b0, 3'd3, 15'h0FE3, 1'b0);
    cyc("fix_ldi_t4", 1, 4'h5, 1'b0, 1'b0, 3'd4, 15'h0FE3, 1'b0);
    cyc("fix_ldi_t5", 1, 4'h5, 1'b0, 1'b0, 3'd5, 15'h0FE3, 1'b0);
    cyc("fix_add_t0", 1, 4'h2, 1'b0, 1'b0, 3'd0, 15'h27E3, 1'b0);
    cyc("fix_add_t1", 1, 4'h2, 1'b0, 1'b0, 3'd1, 15'h4D63, 1'b0);
    cyc("fix_add_t2", 1, 4'h2, 1'b0, 1'b0, 3'd2, 15'h07A3, 1'b0);
    opcode = 4'h2;
    push("fix_add_t3", 1, 3'd3, 15'h0DE1, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_tstate", 32'(ts_f), 32'd0);
    chk("midrst_out", 32'(out_f), 32'h0FE3);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("fix_restart_t0", 1, 4'h2, 1'b0, 1'b0, 3'd0, 15'h27E3, 1'b0);
    cyc("fix_restart_t1", 1, 4'h2, 1'b0, 1'b0, 3'd1, 15'h4D63, 1'b0);

`ifdef CTRL_SINGLE_STEP_EN
    rst_n = 1'b0;
    step = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc("stall", 0, 4'h5, 1'b0, 1'b0, 3'd0, 15'h0FE3, 1'b0);
    step = 1'b1;
    cyc("step_pulse", 0, 4'h5, 1'b0, 1'b0, 3'd0, 15'h27E3, 1'b0);
    step = 1'b0;
    cyc("step_hold0", 0, 4'h5, 1'b0, 1'b0, 3'd1, 15'h0FE3, 1'b0);
    cyc("step_hold1", 0, 4'h5, 1'b0, 1'b0, 3'd1, 15'h0FE3, 1'b0);
    step = 1'b1;
    cyc("step_resume", 0, 4'h5, 1'b0, 1'b0, 3'd1, 15'h4D63, 1'b0);
`endif

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
    chk("scoreboard_drain", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
